// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 system coprocessor: register numbers,
// exception codes and Status/Cause field positions.
package cp0_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned MAX_HW  = 6;

  localparam logic [REG_AW-1:0] REG_BADVADDR = 5'd8;
  localparam logic [REG_AW-1:0] REG_COUNT    = 5'd9;
  localparam logic [REG_AW-1:0] REG_COMPARE  = 5'd11;
  localparam logic [REG_AW-1:0] REG_STATUS   = 5'd12;
  localparam logic [REG_AW-1:0] REG_CAUSE    = 5'd13;
  localparam logic [REG_AW-1:0] REG_EPC      = 5'd14;
  localparam logic [REG_AW-1:0] REG_PRID     = 5'd15;
  localparam logic [REG_AW-1:0] REG_CONFIG   = 5'd16;

  localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [CODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;
  localparam logic [CODE_W-1:0] EXC_TR   = 5'd13;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;

  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_SW_LO  = 8;
  localparam int unsigned CAUSE_IV     = 23;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  localparam logic [XLEN-1:0] STATUS_RESET   = 32'h1000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'hBFC0_0380;

  // BadVAddr only captures on address-error exceptions
  function automatic logic is_addr_exc(input logic [CODE_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: divided Count, Compare and the sticky timer interrupt.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            count_we,
  input  logic            compare_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count,
  output logic [XLEN-1:0] compare,
  output logic            ti
);

  localparam int unsigned DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      compare <= '0;
      div     <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (compare_we) compare <= wdata;

      // a Compare write acknowledges the interrupt and beats a same-cycle match
      if (compare_we) ti <= 1'b0;
      else if ((count == compare) && (compare != '0)) ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// MIPS32 CP0 block: Status/Cause/EPC/BadVAddr, MTC0/MFC0, exception entry,
// ERET, interrupt request and exception-target PC for the commit stage.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int unsigned     NUM_HW_INT = 6,
  parameter int unsigned     COUNT_DIV  = 2,
  parameter logic [XLEN-1:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [XLEN-1:0] CONFIG_VAL = 32'h0000_8000,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_AW-1:0]     waddr_i,
  input  logic [REG_AW-1:0]     raddr_i,
  input  logic [XLEN-1:0]       data_i,
  output logic [XLEN-1:0]       data_o,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [CODE_W-1:0]     exc_code_i,
  input  logic [XLEN-1:0]       exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [XLEN-1:0]       exc_badvaddr_i,
  input  logic                  eret_i,
  output logic                  int_req_o,
  output logic [XLEN-1:0]       exc_target_o,
  output logic [XLEN-1:0]       status_o,
  output logic [XLEN-1:0]       cause_o,
  output logic [XLEN-1:0]       epc_o,
  output logic [XLEN-1:0]       count_o,
  output logic [XLEN-1:0]       compare_o,
  output logic                  timer_int_o
);

  logic [7:0]        im;
  logic              exl, ie;
  logic              bd, iv;
  logic [1:0]        sw;
  logic [CODE_W-1:0] exc_code;
  logic [MAX_HW-1:0] hw_q, hw_ext;
  logic [XLEN-1:0]   epc, badvaddr;
  logic [7:0]        ip;
  logic              wr_status, wr_cause, wr_epc;

  assign wr_status = we_i && (waddr_i == REG_STATUS);
  assign wr_cause  = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc    = we_i && (waddr_i == REG_EPC);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_i && (waddr_i == REG_COUNT)),
    .compare_we (we_i && (waddr_i == REG_COMPARE)),
    .wdata      (data_i),
    .count      (count_o),
    .compare    (compare_o),
    .ti         (timer_int_o)
  );

  // Unused hardware lines are tied off so their IP bits read 0
  always_comb begin
    hw_ext                 = '0;
    hw_ext[NUM_HW_INT-1:0] = hw_int_i;
  end

  // Exception/ERET updates follow the MTC0 updates so they win on shared bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      iv       <= 1'b0;
      sw       <= '0;
      exc_code <= '0;
      hw_q     <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      hw_q <= hw_ext;
      if (wr_status) begin
        im  <= data_i[STATUS_IM_LO +: 8];
        exl <= data_i[STATUS_EXL];
        ie  <= data_i[STATUS_IE];
      end
      if (wr_cause) begin
        iv <= data_i[CAUSE_IV];
        sw <= data_i[CAUSE_SW_LO +: 2];
      end
      if (wr_epc) epc <= data_i;

      if (exc_valid_i) begin
        exc_code <= exc_code_i;
        exl      <= 1'b1;
        if (!exl) begin
          epc <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
          bd  <= exc_bd_i;
        end
        if (is_addr_exc(exc_code_i)) badvaddr <= exc_badvaddr_i;
      end else if (eret_i) begin
        exl <= 1'b0;
      end
    end
  end

  assign ip = {timer_int_o | hw_q[5], hw_q[4:0], sw};

  always_comb begin
    status_o                     = STATUS_RESET;
    status_o[STATUS_IM_LO +: 8]  = im;
    status_o[STATUS_EXL]         = exl;
    status_o[STATUS_IE]          = ie;

    cause_o                      = '0;
    cause_o[CAUSE_BD]            = bd;
    cause_o[CAUSE_TI]            = timer_int_o;
    cause_o[CAUSE_IV]            = iv;
    cause_o[CAUSE_IP_LO +: 8]    = ip;
    cause_o[CAUSE_EXC_LO +: CODE_W] = exc_code;
  end

  assign epc_o     = epc;
  assign int_req_o = ie && !exl && |(ip & im);

  always_comb begin
    exc_target_o = '0;
    if (exc_valid_i) exc_target_o = EXC_VECTOR;
    else if (eret_i) exc_target_o = epc;
  end

  // MFC0 read mux, no write bypass
  always_comb begin
    data_o = '0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr;
      REG_COUNT:    data_o = count_o;
      REG_COMPARE:  data_o = compare_o;
      REG_STATUS:   data_o = status_o;
      REG_CAUSE:    data_o = cause_o;
      REG_EPC:      data_o = epc;
      REG_PRID:     data_o = PRID_VAL;
      REG_CONFIG:   data_o = CONFIG_VAL;
      default:      data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic
// checked against a register-level model of the CP0 rules.
module tb_cp0_unit;

  localparam int unsigned COUNT_DIV = 2;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] PRID = 32'h004C_0102;
  localparam logic [31:0] CONF = 32'h0000_8000;

  logic        clk, rst;
  logic        we, exc_valid, exc_bd, eret;
  logic [4:0]  waddr, raddr, exc_code;
  logic [31:0] wdata, exc_pc, exc_badv;
  logic [5:0]  hw;
  logic [1:0]  hw2;

  logic [31:0] rd_data, exc_target, status, cause, epc, count, compare;
  logic        int_req, ti;
  logic [31:0] d2_rd_data, d2_exc_target, d2_status, d2_cause, d2_epc, d2_count, d2_compare;
  logic        d2_int_req, d2_ti;

  int n_cmp = 0;
  int n_fail = 0;

  assign hw2 = hw[1:0];

  cp0_unit #(.NUM_HW_INT(6), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(wdata),
    .data_o(rd_data), .hw_int_i(hw), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .exc_pc_i(exc_pc), .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_badv), .eret_i(eret),
    .int_req_o(int_req), .exc_target_o(exc_target), .status_o(status), .cause_o(cause),
    .epc_o(epc), .count_o(count), .compare_o(compare), .timer_int_o(ti)
  );

  cp0_unit #(.NUM_HW_INT(2), .COUNT_DIV(3)) dut2 (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(wdata),
    .data_o(d2_rd_data), .hw_int_i(hw2), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .exc_pc_i(exc_pc), .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_badv), .eret_i(eret),
    .int_req_o(d2_int_req), .exc_target_o(d2_exc_target), .status_o(d2_status),
    .cause_o(d2_cause), .epc_o(d2_epc), .count_o(d2_count), .compare_o(d2_compare),
    .timer_int_o(d2_ti)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_cbase, m_compare, m_status, m_epc, m_badv;
  int unsigned m_ticks;
  logic        m_ti, m_bd, m_iv;
  logic [1:0]  m_sw;
  logic [4:0]  m_exc;
  logic [5:0]  m_hw;

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_ticks / COUNT_DIV);
  endfunction

  function automatic logic [31:0] m_cause();
    logic [7:0] ipv;
    ipv = {m_ti | m_hw[5], m_hw[4:0], m_sw};
    return {m_bd, m_ti, 6'b0, m_iv, 7'b0, ipv, 1'b0, m_exc, 2'b0};
  endfunction

  function automatic logic m_intreq();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_target();
    if (exc_valid) return VEC;
    if (eret) return m_epc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CONF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_cbase = 0; m_ticks = 0; m_compare = 0; m_status = 32'h1000_0000;
    m_epc = 0; m_badv = 0; m_ti = 0; m_bd = 0; m_iv = 0; m_sw = 0; m_exc = 0; m_hw = 0;
  endtask

  // Apply one clock's worth of architectural rules to the model
  task automatic model_update();
    logic [31:0] cur;
    logic        old_exl;
    cur = m_count();
    old_exl = m_status[1];
    if (we && waddr == 5'd11) m_ti = 1'b0;
    else if (cur == m_compare && m_compare != 0) m_ti = 1'b1;
    if (we && waddr == 5'd11) m_compare = wdata;
    if (we && waddr == 5'd9) begin m_cbase = wdata; m_ticks = 0; end
    else m_ticks++;
    m_hw = hw;
    if (we && waddr == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
    if (we && waddr == 5'd13) begin m_iv = wdata[23]; m_sw = wdata[9:8]; end
    if (we && waddr == 5'd14) m_epc = wdata;
    if (exc_valid) begin
      m_exc = exc_code;
      if (!old_exl) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_status[1] = 1'b1;
      if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badv;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badv = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0; idle_inputs(); hw = 0; raddr = 5'd15;
    model_reset();
    #1;
    n_cmp++; if (status !== 32'h1000_0000) begin n_fail++; $display("FAIL reset_status: got %h want %h", status, 32'h1000_0000); end
    n_cmp++; if (rd_data !== PRID) begin n_fail++; $display("FAIL reset_prid: got %h want %h", rd_data, PRID); end
    @(negedge clk); rst = 1;
    mtc0(5'd9, 32'h55);
    tick(); tick();
    #2 rst = 0; model_reset();
    #1;
    n_cmp++; if (status !== 32'h1000_0000) begin n_fail++; $display("FAIL midrst_status: got %h want %h", status, 32'h1000_0000); end
    n_cmp++; if (count !== 32'h0) begin n_fail++; $display("FAIL midrst_count: got %h want 0", count); end
    n_cmp++; if (epc !== 32'h0) begin n_fail++; $display("FAIL midrst_epc: got %h want 0", epc); end
    n_cmp++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL midrst_intreq: got %b want 0", int_req); end
    n_cmp++; if (d2_count !== 32'h0) begin n_fail++; $display("FAIL midrst_d2_count: got %h want 0", d2_count); end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (count !== m_count()) begin n_fail++; $display("FAIL post_rst_count[%0d]: got %h want %h", i, count, m_count()); end
    end
    n_cmp++; if (count !== 32'd2) begin n_fail++; $display("FAIL post_rst_count_final: got %h want 2", count); end
    raddr = 5'd16; #1;
    n_cmp++; if (rd_data !== CONF) begin n_fail++; $display("FAIL read_config: got %h want %h", rd_data, CONF); end
  endtask

  task automatic test_timer();
    int guard;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'h10);
    mtc0(5'd9, 32'h0C);
    guard = 0;
    while (count !== 32'h10 && guard < 64) begin
      tick(); guard++;
      n_cmp++; if (ti !== m_ti) begin n_fail++; $display("FAIL timer_ti_track: got %b want %b", ti, m_ti); end
    end
    n_cmp++; if (count !== 32'h10) begin n_fail++; $display("FAIL timer_reach: count %h never reached 10", count); end
    n_cmp++; if (ti !== 1'b0) begin n_fail++; $display("FAIL timer_ti_early: got %b want 0", ti); end
    tick(); #1;
    n_cmp++; if (ti !== 1'b1) begin n_fail++; $display("FAIL timer_ti_set: got %b want 1", ti); end
    n_cmp++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL timer_intreq: got %b want 1", int_req); end
    raddr = 5'd13; #1;
    n_cmp++; if (rd_data !== m_cause()) begin n_fail++; $display("FAIL timer_cause: got %h want %h", rd_data, m_cause()); end
    mtc0(5'd11, 32'h200); #1;
    n_cmp++; if (ti !== 1'b0) begin n_fail++; $display("FAIL timer_ti_clear: got %b want 0", ti); end
  endtask

  task automatic test_delay_slot();
    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'hBFC0_0104; exc_bd = 1; exc_badv = 32'h1234;
    #1;
    n_cmp++; if (exc_target !== VEC) begin n_fail++; $display("FAIL ds_target: got %h want %h", exc_target, VEC); end
    tick(); idle_inputs(); raddr = 5'd8; #1;
    n_cmp++; if (epc !== 32'hBFC0_0100) begin n_fail++; $display("FAIL ds_epc: got %h want bfc00100", epc); end
    n_cmp++; if (cause[31] !== 1'b1) begin n_fail++; $display("FAIL ds_bd: got %b want 1", cause[31]); end
    n_cmp++; if (cause[6:2] !== 5'd12) begin n_fail++; $display("FAIL ds_exccode: got %0d want 12", cause[6:2]); end
    n_cmp++; if (status[1] !== 1'b1) begin n_fail++; $display("FAIL ds_exl: got %b want 1", status[1]); end
    n_cmp++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL ds_badv_untouched: got %h want 0", rd_data); end
  endtask

  task automatic test_nested();
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h8000_1000; exc_bd = 0; exc_badv = 32'h8000_0003;
    tick(); idle_inputs(); raddr = 5'd8; #1;
    n_cmp++; if (epc !== 32'hBFC0_0100) begin n_fail++; $display("FAIL nest_epc: got %h want bfc00100", epc); end
    n_cmp++; if (rd_data !== 32'h8000_0003) begin n_fail++; $display("FAIL nest_badv: got %h want 80000003", rd_data); end
    n_cmp++; if (cause[6:2] !== 5'd4) begin n_fail++; $display("FAIL nest_exccode: got %0d want 4", cause[6:2]); end
    n_cmp++; if (cause[31] !== 1'b1) begin n_fail++; $display("FAIL nest_bd_kept: got %b want 1", cause[31]); end
  endtask

  task automatic test_eret();
    mtc0(5'd14, 32'h8000_2000);
    eret = 1; #1;
    n_cmp++; if (exc_target !== 32'h8000_2000) begin n_fail++; $display("FAIL eret_target: got %h want 80002000", exc_target); end
    tick(); eret = 0; #1;
    n_cmp++; if (status[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b want 0", status[1]); end
    exc_valid = 1; eret = 1; exc_code = 5'd8; exc_pc = 32'h8000_3000; exc_bd = 0; #1;
    n_cmp++; if (exc_target !== VEC) begin n_fail++; $display("FAIL exc_eret_target: got %h want %h", exc_target, VEC); end
    tick(); idle_inputs(); #1;
    n_cmp++; if (status[1] !== 1'b1) begin n_fail++; $display("FAIL exc_eret_exl: got %b want 1", status[1]); end
    n_cmp++; if (epc !== 32'h8000_3000) begin n_fail++; $display("FAIL exc_eret_epc: got %h want 80003000", epc); end
  endtask

  task automatic test_int_mask();
    hw = 6'b000001;
    #1;
    n_cmp++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_exl_pre: got %b want 0", int_req); end
    mtc0(5'd12, 32'h0000_0401); #1;
    n_cmp++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL mask_hw0_req: got %b want 1", int_req); end
    mtc0(5'd12, 32'h0000_0403); #1;
    n_cmp++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_exl_block: got %b want 0", int_req); end
    hw = 6'b100011;
    tick(); #1;
    n_cmp++; if (cause[15:10] !== 6'b100011) begin n_fail++; $display("FAIL ip_hw6: got %b want 100011", cause[15:10]); end
    n_cmp++; if (d2_cause[14:10] !== 5'b00011) begin n_fail++; $display("FAIL ip_hw2: got %b want 00011", d2_cause[14:10]); end
    hw = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 8))
        0: waddr = 5'd8;  1: waddr = 5'd9;  2: waddr = 5'd11; 3: waddr = 5'd12;
        4: waddr = 5'd13; 5: waddr = 5'd14; 6: waddr = 5'd15; 7: waddr = 5'd16;
        default: waddr = 5'($urandom_range(0, 31));
      endcase
      wdata = $urandom();
      if (waddr == 5'd11) wdata = m_count() + 32'($urandom_range(0, 6));
      if (waddr == 5'd9 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFFE;
      hw = 6'($urandom_range(0, 63));
      exc_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0: exc_code = 5'd0;  1: exc_code = 5'd4;  2: exc_code = 5'd5;  3: exc_code = 5'd8;
        4: exc_code = 5'd9;  5: exc_code = 5'd10; 6: exc_code = 5'd12; default: exc_code = 5'd13;
      endcase
      exc_pc = {$urandom()} & 32'hFFFF_FFFC;
      exc_bd = 1'($urandom_range(0, 1));
      exc_badv = $urandom();
      eret = ($urandom_range(0, 5) == 0);
      raddr = 5'($urandom_range(0, 31));
      #1;
      n_cmp++; if (rd_data !== m_read(raddr)) begin n_fail++; $display("FAIL rnd_mfc0[%0d] r%0d: got %h want %h", i, raddr, rd_data, m_read(raddr)); end
      n_cmp++; if (int_req !== m_intreq()) begin n_fail++; $display("FAIL rnd_intreq[%0d]: got %b want %b", i, int_req, m_intreq()); end
      n_cmp++; if (exc_target !== m_target()) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", i, exc_target, m_target()); end
      n_cmp++; if (status !== m_status) begin n_fail++; $display("FAIL rnd_status[%0d]: got %h want %h", i, status, m_status); end
      n_cmp++; if (cause !== m_cause()) begin n_fail++; $display("FAIL rnd_cause[%0d]: got %h want %h", i, cause, m_cause()); end
      n_cmp++; if (epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc, m_epc); end
      n_cmp++; if (count !== m_count()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %h want %h", i, count, m_count()); end
      n_cmp++; if (compare !== m_compare) begin n_fail++; $display("FAIL rnd_compare[%0d]: got %h want %h", i, compare, m_compare); end
      n_cmp++; if (ti !== m_ti) begin n_fail++; $display("FAIL rnd_ti[%0d]: got %b want %b", i, ti, m_ti); end
      tick();
    end
    idle_inputs(); hw = 0;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_delay_slot();
    test_nested();
    test_eret();
    test_int_mask();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
